mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mips_pipe_pkg.sv | 20 ++
 rtl/writeback_register.sv | 32 +++
 rtl/mem_access_stage.sv | 126 ++++++++++++
 tb/tb_mem_access_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS-style pipeline memory stage.
// State encodings, MEM/WB bundle and the default access timeout.
package mips_pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int TIMEOUT_CYC_DEF = 255;

  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] readdata;
    logic [31:0] aluout;
    logic [4:0]  writereg;
  } mem_wb_t;

endpackage

// File: rtl/writeback_register.sv
// MEM/WB pipeline register: load-enable, bubble insert, async reset.
// READDATA only updates when rd_load is set alongside load.
module writeback_register
  import mips_pipe_pkg::*;
(
  input  logic    CLK,
  input  logic    RST,
  input  logic    load,
  input  logic    bubble,
  input  logic    rd_load,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q <= '0;
    end else if (bubble) begin
      q.regwrite <= 1'b0;
      q.memtoreg <= 1'b0;
    end else if (load) begin
      q.regwrite <= d.regwrite;
      q.memtoreg <= d.memtoreg;
      q.aluout   <= d.aluout;
      q.writereg <= d.writereg;
      if (rd_load) begin
        q.readdata <= d.readdata;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory handshake, pipeline stall and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort accesses after TIMEOUT_CYC wait cycles.
module mem_access_stage
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REGWRITEM,
  input  logic        MEMTOREGM,
  input  logic        MEMWRITEM,
  input  logic [31:0] ALUOUTPUTM,
  input  logic [31:0] WRITEDATAM,
  input  logic [4:0]  WRITEREGM,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        STALLM,
  output logic        REGWRITEW,
  output logic        MEMTOREGW,
  output logic [31:0] READDATAW,
  output logic [31:0] ALUOUTPUTW,
  output logic [4:0]  WRITEREGW,
  output logic        MEM_ERR
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be 1..255");
  end

  state_t  state;
  state_t  state_nx;
  logic    memop;
  logic    is_load;
  logic    ack_v;
  logic    tmo;
  logic    bubble;
  mem_wb_t wb_d;
  mem_wb_t wb_q;

  assign memop   = MEMTOREGM | MEMWRITEM;
  assign is_load = MEMTOREGM & ~MEMWRITEM;
  assign ack_v   = memop & DMEM_ACK;

  assign DMEM_REQ   = memop;
  assign DMEM_WE    = MEMWRITEM;
  assign DMEM_ADDR  = ALUOUTPUTM;
  assign DMEM_WDATA = WRITEDATAM;

  // A timed-out access still bubbles but lets EX/MEM move on.
  assign bubble = memop & ~DMEM_ACK;
  assign STALLM = bubble & ~tmo;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (memop & ~DMEM_ACK) state_nx = WAIT;
      WAIT: if (ack_v | tmo)       state_nx = IDLE;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;

  assign tmo = (state == WAIT) & ~ack_v
             & (cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo;
      if (state_nx == IDLE) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  assign MEM_ERR = err_q;
`else
  assign tmo     = 1'b0;
  assign MEM_ERR = 1'b0;
`endif

  always_comb begin
    wb_d          = '0;
    wb_d.regwrite = REGWRITEM & ~MEMWRITEM;
    wb_d.memtoreg = is_load;
    wb_d.readdata = DMEM_RDATA;
    wb_d.aluout   = ALUOUTPUTM;
    wb_d.writereg = WRITEREGM;
  end

  writeback_register u_wb (
    .CLK     (CLK),
    .RST     (RST),
    .load    (~bubble),
    .bubble  (bubble),
    .rd_load (is_load),
    .d       (wb_d),
    .q       (wb_q)
  );

  assign REGWRITEW  = wb_q.regwrite;
  assign MEMTOREGW  = wb_q.memtoreg;
  assign READDATAW  = wb_q.readdata;
  assign ALUOUTPUTW = wb_q.aluout;
  assign WRITEREGW  = wb_q.writereg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table plus handwritten corner cases.
// Timeout checks follow MEM_TIMEOUT_EN; TIMEOUT_CYC is set to 4.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REGWRITEM, MEMTOREGM, MEMWRITEM;
  logic [31:0] ALUOUTPUTM, WRITEDATAM;
  logic [4:0]  WRITEREGM;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic        DMEM_ACK;
  logic        STALLM;
  logic        REGWRITEW, MEMTOREGW;
  logic [31:0] READDATAW, ALUOUTPUTW;
  logic [4:0]  WRITEREGW;
  logic        MEM_ERR;

  always #5 CLK = ~CLK;

  mem_access_stage #(.TIMEOUT_CYC(4)) dut (
    .CLK(CLK), .RST(RST),
    .REGWRITEM(REGWRITEM), .MEMTOREGM(MEMTOREGM),
    .MEMWRITEM(MEMWRITEM), .ALUOUTPUTM(ALUOUTPUTM),
    .WRITEDATAM(WRITEDATAM), .WRITEREGM(WRITEREGM),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .STALLM(STALLM),
    .REGWRITEW(REGWRITEW), .MEMTOREGW(MEMTOREGW),
    .READDATAW(READDATAW), .ALUOUTPUTW(ALUOUTPUTW),
    .WRITEREGW(WRITEREGW), .MEM_ERR(MEM_ERR)
  );

  typedef struct {
    logic        regw, mtr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic        e_regw, e_mtr;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wr;
  } vec_t;

  typedef struct {
    logic        regw, mtr;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
  } wb_exp_t;

  int      n_chk = 0;
  int      n_fail = 0;
  wb_exp_t sb[$];
  vec_t    tbl[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input vec_t v);
    REGWRITEM  = v.regw;
    MEMTOREGM  = v.mtr;
    MEMWRITEM  = v.mw;
    ALUOUTPUTM = v.alu;
    WRITEDATAM = v.wd;
    WRITEREGM  = v.wr;
    DMEM_RDATA = v.rdata;
    DMEM_ACK   = v.ack;
  endtask

  task automatic chk_wb(input string nm, input wb_exp_t e);
    chk({nm, ".regw"}, 32'(REGWRITEW), 32'(e.regw));
    chk({nm, ".mtr"},  32'(MEMTOREGW), 32'(e.mtr));
    chk({nm, ".rd"},   READDATAW, e.rd);
    chk({nm, ".alu"},  ALUOUTPUTW, e.alu);
    chk({nm, ".wr"},   32'(WRITEREGW), 32'(e.wr));
  endtask

  // Called 1 time unit after a rising edge; returns likewise.
  task automatic apply(input string nm, input vec_t v);
    wb_exp_t e;
    set_in(v);
    #3;
    chk({nm, ".stall"}, 32'(STALLM), 32'(v.stall));
    chk({nm, ".req"},   32'(DMEM_REQ), 32'(v.mtr | v.mw));
    chk({nm, ".we"},    32'(DMEM_WE), 32'(v.mw));
    chk({nm, ".addr"},  DMEM_ADDR, v.alu);
    chk({nm, ".wdata"}, DMEM_WDATA, v.wd);
    e = '{v.e_regw, v.e_mtr, v.e_rd, v.e_alu, v.e_wr};
    sb.push_back(e);
    @(posedge CLK); #1;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s.sb: queue empty", nm);
    end else begin
      chk_wb(nm, sb.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t    v;
    vec_t    nop;
    wb_exp_t hold;

    // regw mtr mw alu wd wr rdata ack | stall | W regw mtr rd alu wr
    tbl[0]  = '{1,0,0,32'h10,0,5,0,0, 0, 1,0,0,32'h10,5};
    tbl[1]  = '{1,1,0,32'h100,0,8,32'hDEADBEEF,1,
                0, 1,1,32'hDEADBEEF,32'h100,8};
    tbl[2]  = '{0,0,1,32'h200,32'h12345678,0,0,0,
                1, 0,0,32'hDEADBEEF,32'h100,8};
    tbl[3]  = tbl[2];
    tbl[4]  = tbl[2];
    tbl[5]  = '{0,0,1,32'h200,32'h12345678,0,0,1,
                0, 0,0,32'hDEADBEEF,32'h200,0};
    tbl[6]  = '{1,0,0,32'h33,0,3,32'hCAFEF00D,1,
                0, 1,0,32'hDEADBEEF,32'h33,3};
    tbl[7]  = '{1,1,0,32'h104,0,9,32'h11111111,1,
                0, 1,1,32'h11111111,32'h104,9};
    tbl[8]  = '{1,1,1,32'h300,32'hAA,10,32'h22222222,1,
                0, 0,0,32'h11111111,32'h300,10};
    tbl[9]  = '{1,1,0,32'h400,0,11,32'h5555,0,
                1, 0,0,32'h11111111,32'h300,10};
    tbl[10] = '{1,1,0,32'h400,0,11,32'h66666666,1,
                0, 1,1,32'h66666666,32'h400,11};
    tbl[11] = '{0,0,0,32'h44,0,12,0,0,
                0, 0,0,32'h66666666,32'h44,12};

    nop = '{0,0,0,0,0,0,0,0, 0, 0,0,0,0,0};
    RST = 1'b0;
    set_in(nop);
    #12;
    chk_wb("rst", '{0,0,0,0,0});
    chk("rst.err", 32'(MEM_ERR), 0);
    chk("rst.stall", 32'(STALLM), 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Load that is never acknowledged.
    hold = '{0,0,32'h66666666,32'h44,12};
    v = '{1,1,0,32'h500,0,13,32'h99,0,
          1, 0,0,32'h66666666,32'h44,12};
    set_in(v);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 5; i++) begin
      #3;
      chk($sformatf("tmo%0d.stall", i),
          32'(STALLM), 32'(i < 4));
      @(posedge CLK); #1;
      chk_wb($sformatf("tmo%0d", i), hold);
      chk($sformatf("tmo%0d.err", i),
          32'(MEM_ERR), 32'(i == 4));
    end
    set_in(nop);
    @(posedge CLK); #1;
    chk("tmo.err_off", 32'(MEM_ERR), 0);
    chk("tmo.idle_alu", ALUOUTPUTW, 0);
`else
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("hang%0d.stall", i), 32'(STALLM), 1);
      @(posedge CLK); #1;
      chk_wb($sformatf("hang%0d", i), hold);
      chk($sformatf("hang%0d.err", i), 32'(MEM_ERR), 0);
    end
`endif

    // Reset while a load is waiting.
    v = '{1,1,0,32'h580,0,15,32'h1234,0,
          1, 0,0,0,0,0};
    set_in(v);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    #1 RST = 1'b0;
    #1;
    chk_wb("rstw", '{0,0,0,0,0});
    chk("rstw.err", 32'(MEM_ERR), 0);
    set_in(nop);
    #1;
    chk("rstw.req", 32'(DMEM_REQ), 0);
    chk("rstw.stall", 32'(STALLM), 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    v = '{1,1,0,32'h600,0,14,32'h77777777,0,
          1, 0,0,0,0,0};
    apply("post_rst_w", v);
    v.ack = 1'b1; v.stall = 1'b0;
    v.e_regw = 1; v.e_mtr = 1;
    v.e_rd = 32'h77777777; v.e_alu = 32'h600; v.e_wr = 14;
    apply("post_rst", v);
    apply("post_nop", '{0,0,0,32'h8,0,1,32'h1,1,
                        0, 0,0,32'h77777777,32'h8,1});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
